ysyx_23060042_decode_stage: RTL and testbench

Pipelined RV32I/RV64I decode stage between the IFU and EXU of the NPC core. It accepts fetched instructions over a valid/ready handshake and decodes register indices, the sign-extended immediate, the immediate type, control enables and an illegal-instruction flag. Decoded bundles are held in a parametrised FIFO so the EXU can back-pressure without stalling fetch immediately. A flush input discards all buffered work on a PC redirect.

---
 rtl/ysyx_23060042_decode_stage.sv | 166 ++++++++++++++++
 tb/tb_ysyx_23060042_decode_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060042_decode_stage.sv
// ysyx_23060042_decode_stage: RV32I/RV64I decode into a DEPTH-entry bundle FIFO; optional RV32E register check via DECODE_RVE_EN
module ysyx_23060042_decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_func3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic            out_regen,
    output logic            out_pcjen,
    output logic            out_pcren,
    output logic            out_branch,
    output logic            out_illegal
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [2:0]      imm_type;
        logic            regen;
        logic            pcjen;
        logic            pcren;
        logic            branch;
        logic            illegal;
    } bundle_t;

    bundle_t       dec, head;
    bundle_t       mem_q [DEPTH];
    bundle_t       mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   imm32;
    logic          push, pop;

    // full blocks new work even when the head pops in the same cycle
    assign in_ready  = (count_q != (AW+1)'(DEPTH)) && !flush;
    assign out_valid = count_q != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // combinational decode of the offered instruction into a bundle
    always_comb begin
        dec          = '0;
        imm32        = '0;
        dec.pc       = in_pc;
        dec.opcode   = in_inst[6:0];
        dec.func3    = in_inst[14:12];
        dec.rs1      = in_inst[19:15];
        dec.rs2      = in_inst[24:20];
        dec.rd       = in_inst[11:7];
        case (in_inst[6:0])
            7'b0110111, 7'b0010111: begin
                dec.imm_type = 3'b110;
                imm32        = {in_inst[31:12], 12'b0};
                dec.regen    = 1'b1;
            end
            7'b1101111: begin
                dec.imm_type = 3'b111;
                imm32        = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
                dec.regen    = 1'b1;
                dec.pcjen    = 1'b1;
            end
            7'b1100111: begin
                dec.imm_type = 3'b001;
                imm32        = {{20{in_inst[31]}}, in_inst[31:20]};
                dec.regen    = 1'b1;
                dec.pcren    = 1'b1;
            end
            7'b1100011: begin
                dec.imm_type = 3'b011;
                imm32        = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
                dec.branch   = 1'b1;
            end
            7'b0000011, 7'b0010011: begin
                dec.imm_type = 3'b001;
                imm32        = {{20{in_inst[31]}}, in_inst[31:20]};
                dec.regen    = 1'b1;
            end
            7'b0100011: begin
                dec.imm_type = 3'b010;
                imm32        = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            7'b0110011: dec.regen = 1'b1;
            7'b1110011: begin
                dec.imm_type = 3'b001;
                imm32        = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.imm   = XLEN'($signed(imm32));
        dec.regen = dec.regen && (in_inst[11:7] != 5'd0);
`ifdef DECODE_RVE_EN
        if ((dec.imm_type inside {3'b000, 3'b001, 3'b010, 3'b011} && in_inst[19]) ||
            (dec.imm_type inside {3'b000, 3'b010, 3'b011} && in_inst[24]) ||
            (dec.imm_type inside {3'b000, 3'b001, 3'b110, 3'b111} && in_inst[11])) begin
            dec.illegal = 1'b1;
            dec.regen   = 1'b0;
            dec.pcjen   = 1'b0;
            dec.pcren   = 1'b0;
            dec.branch  = 1'b0;
        end
`endif
    end

    // next FIFO state: write at tail, advance pointers, flush empties everything
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wptr_q] = dec;
        wptr_d  = flush ? '0 : wptr_q + AW'(push);
        rptr_d  = flush ? '0 : rptr_q + AW'(pop);
        count_d = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    // pointer and occupancy registers, reset wins over flush
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // bundle storage; contents are masked at the output while empty
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head         = out_valid ? mem_q[rptr_q] : '0;
    assign out_pc       = head.pc;
    assign out_opcode   = head.opcode;
    assign out_func3    = head.func3;
    assign out_rs1      = head.rs1;
    assign out_rs2      = head.rs2;
    assign out_rd       = head.rd;
    assign out_imm      = head.imm;
    assign out_imm_type = head.imm_type;
    assign out_regen    = head.regen;
    assign out_pcjen    = head.pcjen;
    assign out_pcren    = head.pcren;
    assign out_branch   = head.branch;
    assign out_illegal  = head.illegal;
endmodule

// File: tb/tb_ysyx_23060042_decode_stage.sv
// tb_ysyx_23060042_decode_stage: scoreboard bench for the decode stage FIFO
module tb_ysyx_23060042_decode_stage;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_inst = 0, in_pc = 0;
    logic in_ready, out_valid;
    logic [31:0] out_pc, out_imm;
    logic [6:0] out_opcode;
    logic [2:0] out_func3, out_imm_type;
    logic [4:0] out_rs1, out_rs2, out_rd;
    logic out_regen, out_pcjen, out_pcren, out_branch, out_illegal;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [2:0]  imm_type;
        logic        regen, pcjen, pcren, branch, illegal;
    } exp_t;

    exp_t q[$];
    int   vectors = 0, miscompares = 0;
    bit   mon_en = 0;

    ysyx_23060042_decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opcode(out_opcode), .out_func3(out_func3), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm), .out_imm_type(out_imm_type),
        .out_regen(out_regen), .out_pcjen(out_pcjen), .out_pcren(out_pcren),
        .out_branch(out_branch), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // reference decode built from the opcode table and immediate bit layouts
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        int   s, imm;
        e = '0;
        s = int'(inst);
        imm = 0;
        e.pc = pc; e.opcode = inst[6:0]; e.func3 = inst[14:12];
        e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.rd = inst[11:7];
        case (inst[6:0])
            7'h37, 7'h17: begin e.imm_type = 3'b110; e.regen = 1; end
            7'h6F: begin e.imm_type = 3'b111; e.regen = 1; e.pcjen = 1; end
            7'h67: begin e.imm_type = 3'b001; e.regen = 1; e.pcren = 1; end
            7'h63: begin e.imm_type = 3'b011; e.branch = 1; end
            7'h03, 7'h13: begin e.imm_type = 3'b001; e.regen = 1; end
            7'h23: e.imm_type = 3'b010;
            7'h33: e.regen = 1;
            7'h73: e.imm_type = 3'b001;
            default: e.illegal = 1;
        endcase
        case (e.imm_type)
            3'b001: imm = s >>> 20;
            3'b010: imm = ((s >>> 25) << 5) | int'(inst[11:7]);
            3'b011: imm = ((s >>> 31) << 12) | (int'(inst[7]) << 11) | (int'(inst[30:25]) << 5) | (int'(inst[11:8]) << 1);
            3'b110: imm = s & 32'hFFFFF000;
            3'b111: imm = ((s >>> 31) << 20) | (int'(inst[19:12]) << 12) | (int'(inst[20]) << 11) | (int'(inst[30:21]) << 1);
            default: imm = 0;
        endcase
        e.imm = imm;
        if (e.rd == 0) e.regen = 0;
`ifdef DECODE_RVE_EN
        if ((e.imm_type inside {3'b000, 3'b001, 3'b010, 3'b011} && e.rs1 >= 16) ||
            (e.imm_type inside {3'b000, 3'b010, 3'b011} && e.rs2 >= 16) ||
            (e.imm_type inside {3'b000, 3'b001, 3'b110, 3'b111} && e.rd >= 16)) begin
            e.illegal = 1; e.regen = 0; e.pcjen = 0; e.pcren = 0; e.branch = 0;
        end
`endif
        return e;
    endfunction

    // monitor: compares handshake and head contents against the scoreboard
    always @(negedge clk) begin
        exp_t got;
        if (mon_en) begin
            got = {out_pc, out_opcode, out_func3, out_rs1, out_rs2, out_rd, out_imm, out_imm_type,
                   out_regen, out_pcjen, out_pcren, out_branch, out_illegal};
            vectors++;
            if (out_valid !== (q.size() != 0)) begin
                miscompares++;
                $display("FAIL valid t=%0t: got %b expected %b", $time, out_valid, q.size() != 0);
            end
            vectors++;
            if (in_ready !== (q.size() < DEPTH && !flush)) begin
                miscompares++;
                $display("FAIL in_ready t=%0t: got %b expected %b", $time, in_ready, q.size() < DEPTH && !flush);
            end
            if (out_valid === 1'b1 && q.size() != 0) begin
                vectors++;
                if (got !== q[0]) begin
                    miscompares++;
                    $display("FAIL bundle t=%0t: got %h expected %h", $time, got, q[0]);
                end
                if (out_ready) void'(q.pop_front());
            end else if (out_valid !== 1'b1) begin
                vectors++;
                if (got !== '0) begin
                    miscompares++;
                    $display("FAIL idle_zero t=%0t: got %h expected 0", $time, got);
                end
            end
        end
    end

    // recorder: after the monitor, note what the coming edge will accept or discard
    always @(negedge clk) begin
        #2;
        if (rst || flush) q.delete();
        else if (in_valid && in_ready) q.push_back(model(in_inst, in_pc));
    end

    task automatic cyc(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    endtask

    task automatic check_head(input string name, input logic [31:0] imm, input logic [2:0] t,
                              input logic [4:0] f);
        vectors++;
        if (out_valid !== 1'b1 || out_imm !== imm || out_imm_type !== t ||
            {out_regen, out_pcjen, out_pcren, out_branch, out_illegal} !== f) begin
            miscompares++;
            $display("FAIL %s: got valid=%b imm=%h type=%b flags=%b expected valid=1 imm=%h type=%b flags=%b",
                     name, out_valid, out_imm, out_imm_type,
                     {out_regen, out_pcjen, out_pcren, out_branch, out_illegal}, imm, t, f);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    logic [31:0] d_inst [4] = '{32'h00500093, 32'hFFDFF0EF, 32'hFE209CE3, 32'h0000007F};
    logic [31:0] d_imm  [4] = '{32'h5, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h0};
    logic [2:0]  d_type [4] = '{3'b001, 3'b111, 3'b011, 3'b000};
    logic [4:0]  d_flag [4] = '{5'b10000, 5'b11000, 5'b00010, 5'b00001};
    logic [6:0]  ops    [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};

    initial begin
        logic [31:0] r;
        logic [6:0]  op;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        mon_en = 1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 0 || in_ready !== 1 || out_pc !== 0 || out_imm !== 0 || out_rd !== 0) begin
            miscompares++;
            $display("FAIL reset: got valid=%b ready=%b pc=%h imm=%h rd=%0d expected 0 1 0 0 0",
                     out_valid, in_ready, out_pc, out_imm, out_rd);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1, d_inst[i], 32'h8000_0000 + 32'(i * 4), 1, 0);
            cyc(0, 0, 0, 1, 0);
            @(negedge clk);
            check_head($sformatf("directed%0d", i), d_imm[i], d_type[i], d_flag[i]);
        end
`ifdef DECODE_RVE_EN
        cyc(1, 32'h002088B3, 32'h8000_0100, 1, 0);
        cyc(0, 0, 0, 1, 0);
        @(negedge clk);
        check_head("rve_add_x17", 32'h0, 3'b000, 5'b00001);
`endif
        for (int k = 0; k <= DEPTH; k++) cyc(1, 32'h00100093 + 32'(k << 20), 32'h100 + 32'(k * 4), 0, 0);
        @(negedge clk);
        check_bit("full_ready", in_ready, 1'b0);
        cyc(1, 32'h00000013, 32'h200, 1, 0);
        @(negedge clk);
        check_bit("full_pop_ready", in_ready, 1'b0);
        for (int k = 0; k < DEPTH + 1; k++) cyc(0, 0, 0, 1, 0);
        for (int k = 0; k < 16; k++) begin
            r = $urandom;
            cyc(1, {r[31:7], ops[k % 10]}, 32'h300 + 32'(k * 4), 1, 0);
            @(negedge clk);
            if (k > 0) check_bit("stream_valid", out_valid, 1'b1);
        end
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 32'h00500093, 32'h400, 0, 0);
        cyc(1, 32'h00600113, 32'h404, 0, 0);
        cyc(1, 32'h00700193, 32'h408, 0, 1);
        cyc(0, 0, 0, 1, 0);
        @(negedge clk);
        check_bit("flush_valid", out_valid, 1'b0);
        repeat (3) cyc(0, 0, 0, 1, 0);
        for (int k = 0; k < 600; k++) begin
            r  = $urandom;
            op = ($urandom % 6 == 0) ? r[6:0] : ops[$urandom % 10];
            cyc($urandom % 4 != 0, {r[31:7], op}, $urandom & 32'hFFFFFFFC,
                $urandom % 3 != 0, $urandom % 25 == 0);
            rst = ($urandom % 80 == 0);
        end
        rst = 0;
        repeat (DEPTH + 2) cyc(0, 0, 0, 1, 0);
        @(negedge clk);
        vectors++;
        if (q.size() != 0 || out_valid !== 0) begin
            miscompares++;
            $display("FAIL drain: got pending=%0d valid=%b expected 0 0", q.size(), out_valid);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
